// File: rtl/l_msu_seq_if.sv
// Term/result bus of the saturating multiply-subtract accumulator.
// result_rnd exists only when MSU_ROUND_EN is defined.
interface l_msu_seq_if;
  logic        start;
  logic [31:0] init;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] var1;
  logic [15:0] var2;
  logic        last;
  logic        done;
  logic [31:0] result;
  logic        overflow;
`ifdef MSU_ROUND_EN
  logic [15:0] result_rnd;
`endif

  modport slave (
    input  start, init, in_valid, var1, var2, last,
    output in_ready, done, result, overflow
`ifdef MSU_ROUND_EN
    , output result_rnd
`endif
  );

  modport master (
    output start, init, in_valid, var1, var2, last,
    input  in_ready, done, result, overflow
`ifdef MSU_ROUND_EN
    , input result_rnd
`endif
  );
endinterface

// File: rtl/l_msu_seq.sv
// Sequential G.729 L_msu: result = init - sum(L_mult(var1,var2)), saturating each step.
// Optional MSU_ROUND_EN adds result_rnd = extract_h(L_add(result, 0x8000)).
//
// state   | meaning
// IDLE    | waiting for start, in_ready=0
// RUN     | accepting one term per clock
// FLUSH   | last product in flight to the accumulator
// DONE    | one-cycle done pulse, result final
module l_msu_seq #(
  parameter int MAX_TERMS = 40,
  parameter int CNT_W     = 6
) (
  input logic        clock,
  input logic        reset,
  l_msu_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      prod_q, prod_d;
  logic             p_vld_q, p_vld_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      mult_full;
  logic [31:0]      mult_res;
  logic             mult_sat;
  logic [31:0]      diff;
  logic             sub_sat;
  logic [31:0]      sub_res;

  assign accept  = bus.in_valid && (state_q == S_RUN);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Only -1 * -1 (0x8000 squared) overflows after the doubling shift.
  assign mult_full = {{16{bus.var1[15]}}, bus.var1} * {{16{bus.var2[15]}}, bus.var2};
  assign mult_sat  = (bus.var1 == 16'h8000) && (bus.var2 == 16'h8000);
  assign mult_res  = mult_sat ? 32'h7FFF_FFFF : {mult_full[30:0], 1'b0};

  assign diff    = acc_q - prod_q;
  assign sub_sat = (acc_q[31] != prod_q[31]) && (diff[31] != acc_q[31]);
  assign sub_res = sub_sat ? (acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : diff;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    p_vld_d = 1'b0;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (p_vld_q) begin
      acc_d = sub_res;
      if (sub_sat) ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = bus.init;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          prod_d  = mult_res;
          p_vld_d = 1'b1;
          cnt_d   = cnt_inc;
          if (mult_sat) ovf_d = 1'b1;
          // Reaching MAX_TERMS ends the run, so the counter can never wrap.
          if (bus.last || (cnt_inc == CNT_W'(MAX_TERMS))) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (p_vld_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      prod_q  <= '0;
      p_vld_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      p_vld_q <= p_vld_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = acc_q;
  assign bus.overflow = ovf_q;

`ifdef MSU_ROUND_EN
  logic [31:0] rnd_sum;
  logic        rnd_sat;

  // Adding a positive constant can only overflow upward.
  assign rnd_sum        = acc_q + 32'h0000_8000;
  assign rnd_sat        = !acc_q[31] && rnd_sum[31];
  assign bus.result_rnd = rnd_sat ? 16'h7FFF : rnd_sum[31:16];
`endif
endmodule
